// File: rtl/data_writeback_nway_cache.sv
// N-way set-associative write-back, write-allocate L1 data cache with single-word bus refill/writeback.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module data_writeback_nway_cache #(
   parameter int unsigned WAYS      = 4,
   parameter int unsigned BLOCKSIZE = 4,
   parameter int unsigned LINES     = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic [3:0]  ByteMask,
   input  logic [31:0] HRData,
   input  logic        BusReady,
   output logic [31:0] RD,
   output logic        Stall,
   output logic        HRequestM,
   output logic        HWriteM,
   output logic [31:0] HAddr,
   output logic [31:0] HWData
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] HitCount,
   output logic [31:0] MissCount
`endif
);

   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned OFF_W = $clog2(BLOCKSIZE);
   localparam int unsigned SET_W = $clog2(LINES);
   localparam int unsigned TAG_W = 30 - OFF_W - SET_W;

   typedef enum logic [1:0] {READY, WRITEBACK, FETCH} state_t;

   logic [31:0]      data_q  [WAYS][LINES][BLOCKSIZE];
   logic [TAG_W-1:0] tag_q   [WAYS][LINES];
   logic [WAYS-1:0]  valid_q [LINES];
   logic [WAYS-1:0]  dirty_q [LINES];
   logic [WAY_W-1:0] rr_q    [LINES];

   state_t           state_q, state_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;
   logic [WAY_W-1:0] victim_q, victim_d;

   logic [TAG_W-1:0] a_tag;
   logic [SET_W-1:0] a_set;
   logic [OFF_W-1:0] a_off;
   logic             req;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] vic_sel;
   logic [31:0]      store_word;
   logic             store_we, fill_we, wb_done, line_done, miss_start, hit_ok;
   logic             unused_bits;

   assign a_off       = A[OFF_W+1:2];
   assign a_set       = A[SET_W+OFF_W+1:OFF_W+2];
   assign a_tag       = A[31:SET_W+OFF_W+2];
   assign req         = MemWriteM | MemtoRegM;
   assign unused_bits = &{1'b0, A[1:0]};

   // Tag lookup and victim choice: lowest invalid way, else the set's round-robin pointer
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[a_set][w] && (tag_q[w][a_set] == a_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      vic_sel = rr_q[a_set];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[a_set][w]) vic_sel = WAY_W'(w);
      end
   end

   // Byte-masked merge of store data into the hit word
   always_comb begin
      store_word = data_q[hit_way][a_set][a_off];
      for (int b = 0; b < 4; b++) begin
         if (ByteMask[b]) store_word[8*b +: 8] = WD[8*b +: 8];
      end
   end

   // Next-state and outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      victim_d   = victim_q;
      RD         = '0;
      Stall      = 1'b0;
      HRequestM  = 1'b0;
      HWriteM    = 1'b0;
      HAddr      = '0;
      HWData     = '0;
      store_we   = 1'b0;
      fill_we    = 1'b0;
      wb_done    = 1'b0;
      line_done  = 1'b0;
      miss_start = 1'b0;
      hit_ok     = 1'b0;
      case (state_q)
         READY: begin
            if (req) begin
               if (hit) begin
                  hit_ok   = 1'b1;
                  store_we = MemWriteM;
                  if (MemtoRegM) RD = data_q[hit_way][a_set][a_off];
               end else begin
                  Stall      = 1'b1;
                  miss_start = 1'b1;
                  victim_d   = vic_sel;
                  state_d    = (valid_q[a_set][vic_sel] && dirty_q[a_set][vic_sel]) ? WRITEBACK : FETCH;
               end
            end
         end
         WRITEBACK: begin
            Stall     = 1'b1;
            HRequestM = 1'b1;
            HWriteM   = 1'b1;
            HAddr     = {tag_q[victim_q][a_set], a_set, cnt_q, 2'b00};
            HWData    = data_q[victim_q][a_set][cnt_q];
            if (BusReady) begin
               if (cnt_q == OFF_W'(BLOCKSIZE - 1)) begin
                  cnt_d   = '0;
                  wb_done = 1'b1;
                  state_d = FETCH;
               end else begin
                  cnt_d = cnt_q + OFF_W'(1);
               end
            end
         end
         FETCH: begin
            Stall     = 1'b1;
            HRequestM = 1'b1;
            HAddr     = {a_tag, a_set, cnt_q, 2'b00};
            if (BusReady) begin
               fill_we = 1'b1;
               if (cnt_q == OFF_W'(BLOCKSIZE - 1)) begin
                  cnt_d     = '0;
                  line_done = 1'b1;
                  state_d   = READY;
               end else begin
                  cnt_d = cnt_q + OFF_W'(1);
               end
            end
         end
         default: state_d = READY;
      endcase
   end

   // Control state and per-set line status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= READY;
         cnt_q    <= '0;
         victim_q <= '0;
         for (int s = 0; s < LINES; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         victim_q <= victim_d;
         if (store_we) dirty_q[a_set][hit_way] <= 1'b1;
         if (wb_done) dirty_q[a_set][victim_q] <= 1'b0;
         if (line_done) begin
            valid_q[a_set][victim_q] <= 1'b1;
            dirty_q[a_set][victim_q] <= 1'b0;
            rr_q[a_set]              <= victim_q + WAY_W'(1);
         end
      end
   end

   // Data and tag arrays carry no reset; validity is tracked separately
   always_ff @(posedge clk) begin
      if (store_we) data_q[hit_way][a_set][a_off] <= store_word;
      if (fill_we) data_q[victim_q][a_set][cnt_q] <= HRData;
      if (line_done) tag_q[victim_q][a_set] <= a_tag;
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else begin
         if (hit_ok) HitCount <= HitCount + 32'd1;
         if (miss_start) MissCount <= MissCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_writeback_nway_cache.sv
// Directed bench for data_writeback_nway_cache: refill, store merge, dirty eviction, bus wait states, reset abort.
module tb_data_writeback_nway_cache;

   logic        clk;
   logic        reset;
   logic        mem_write, mem_to_reg;
   logic [31:0] addr, wd;
   logic [3:0]  byte_mask;
   logic [31:0] hrdata;
   logic        bus_ready;
   logic [31:0] rd;
   logic        stall, hreq, hwrite;
   logic [31:0] haddr, hwdata;
   logic [31:0] fill_base;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
   int          sb_hits, sb_miss;
`endif

   int          total, bad;
   int          st;
   logic [31:0] lg_addr[$];
   logic [31:0] lg_data[$];
   logic        lg_wr[$];
   logic        lg_rdy[$];
   logic        rdy_q[$];
   logic [31:0] s4_addr [6] = '{32'h200, 32'h204, 32'h204, 32'h204, 32'h208, 32'h20C};
   logic        s4_rdy  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   data_writeback_nway_cache dut (
      .clk       (clk),
      .reset     (reset),
      .MemWriteM (mem_write),
      .MemtoRegM (mem_to_reg),
      .A         (addr),
      .WD        (wd),
      .ByteMask  (byte_mask),
      .HRData    (hrdata),
      .BusReady  (bus_ready),
      .RD        (rd),
      .Stall     (stall),
      .HRequestM (hreq),
      .HWriteM   (hwrite),
      .HAddr     (haddr),
      .HWData    (hwdata)
`ifdef DCACHE_STATS_EN
      ,
      .HitCount  (hit_count),
      .MissCount (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus slave: word n of any refilled block returns fill_base + n
   assign hrdata = fill_base + 32'(haddr[3:2]);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one access and run until Stall drops, logging every bus request cycle
   task automatic access(input logic [31:0] a, input logic is_st, input logic [31:0] d,
                         input logic [3:0] bm, output int stalls);
      addr = a; wd = d; byte_mask = bm;
      mem_write = is_st; mem_to_reg = !is_st;
      stalls = 0;
      lg_addr.delete(); lg_data.delete(); lg_wr.delete(); lg_rdy.delete();
      for (int c = 0; c < 60; c++) begin
         bus_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
         #1;
         if (!stall) begin
`ifdef DCACHE_STATS_EN
            sb_hits++;
            if (stalls > 0) sb_miss++;
`endif
            return;
         end
         stalls++;
         if (hreq) begin
            lg_addr.push_back(haddr);
            lg_data.push_back(hwdata);
            lg_wr.push_back(hwrite);
            lg_rdy.push_back(bus_ready);
         end
         @(posedge clk); #1;
      end
      check("stall_timeout", 32'(stall), 32'd0);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      mem_write = 1'b0; mem_to_reg = 1'b0; bus_ready = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
      addr = '0; wd = '0; byte_mask = '0; bus_ready = 1'b0; fill_base = '0;
`ifdef DCACHE_STATS_EN
      sb_hits = 0; sb_miss = 0;
`endif
      #12;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_hreq", 32'(hreq), 32'd0);
      check("rst_hwrite", 32'(hwrite), 32'd0);
      check("rst_haddr", haddr, 32'd0);
      check("rst_hwdata", hwdata, 32'd0);
      check("rst_rd", rd, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // 1: clean refill of 0x100
      fill_base = 32'hA0;
      access(32'h100, 1'b0, 32'h0, 4'h0, st);
      check("s1_stalls", 32'(st), 32'd5);
      check("s1_beats", 32'(lg_addr.size()), 32'd4);
      for (int i = 0; i < lg_addr.size(); i++) begin
         check("s1_addr", lg_addr[i], 32'h100 + 32'(4 * i));
         check("s1_wr", 32'(lg_wr[i]), 32'd0);
      end
      check("s1_rd", rd, 32'hA0);
      idle();

      // 2: byte-masked store hit, then readback
      access(32'h104, 1'b1, 32'hDEADBEEF, 4'b0011, st);
      check("s2_st_stalls", 32'(st), 32'd0);
      idle();
      access(32'h104, 1'b0, 32'h0, 4'h0, st);
      check("s2_ld_stalls", 32'(st), 32'd0);
      check("s2_rd", rd, 32'h0000BEEF);
      idle();

      // 3: fill all ways of set 0, dirty way 0, then evict it
      for (int t = 0; t < 4; t++) begin
         fill_base = 32'h1000 * 32'(t + 1);
         access(32'h400 * 32'(t), 1'b0, 32'h0, 4'h0, st);
         check("s3_fill_stalls", 32'(st), 32'd5);
         check("s3_fill_rd", rd, fill_base);
         idle();
      end
      access(32'h000, 1'b1, 32'h11223344, 4'hF, st);
      check("s3_dirty_stalls", 32'(st), 32'd0);
      idle();
      fill_base = 32'h5000;
      access(32'h1000, 1'b0, 32'h0, 4'h0, st);
      check("s3_evict_stalls", 32'(st), 32'd9);
      check("s3_evict_beats", 32'(lg_addr.size()), 32'd8);
      for (int i = 0; i < 4 && i < lg_addr.size(); i++) begin
         check("s3_wb_wr", 32'(lg_wr[i]), 32'd1);
         check("s3_wb_addr", lg_addr[i], 32'(4 * i));
         check("s3_wb_data", lg_data[i], (i == 0) ? 32'h11223344 : 32'h1000 + 32'(i));
      end
      for (int i = 4; i < lg_addr.size(); i++) begin
         check("s3_rf_wr", 32'(lg_wr[i]), 32'd0);
         check("s3_rf_addr", lg_addr[i], 32'h1000 + 32'(4 * (i - 4)));
      end
      check("s3_evict_rd", rd, 32'h5000);
      idle();
      access(32'h400, 1'b0, 32'h0, 4'h0, st);
      check("s3_way1_stalls", 32'(st), 32'd0);
      check("s3_way1_rd", rd, 32'h2000);
      idle();
      fill_base = 32'h6000;
      access(32'h004, 1'b0, 32'h0, 4'h0, st);
      check("s3_rr_stalls", 32'(st), 32'd5);
      check("s3_rr_rd", rd, 32'h6001);
      idle();
`ifdef DCACHE_STATS_EN
      check("s3_hitcount", hit_count, 32'(sb_hits));
      check("s3_misscount", miss_count, 32'(sb_miss));
`endif

      // 4: wait states during refill
      fill_base = 32'h300;
      rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      access(32'h200, 1'b0, 32'h0, 4'h0, st);
      check("s4_stalls", 32'(st), 32'd7);
      check("s4_req_cycles", 32'(lg_addr.size()), 32'd6);
      for (int i = 0; i < 6 && i < lg_addr.size(); i++) begin
         check("s4_addr", lg_addr[i], s4_addr[i]);
         check("s4_rdy", 32'(lg_rdy[i]), 32'(s4_rdy[i]));
      end
      check("s4_rd", rd, 32'h300);
      idle();
      access(32'h20C, 1'b0, 32'h0, 4'h0, st);
      check("s4_w3_rd", rd, 32'h303);
      idle();
      access(32'h204, 1'b0, 32'h0, 4'h0, st);
      check("s4_w1_rd", rd, 32'h301);
      idle();

      // 5: reset during the second refill beat
      fill_base = 32'h700;
      addr = 32'h300; mem_to_reg = 1'b1; bus_ready = 1'b1;
      #1;
      check("s5_miss_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      check("s5_beat0_addr", haddr, 32'h300);
      @(posedge clk); #1;
      check("s5_beat1_addr", haddr, 32'h304);
      reset = 1'b0;
      #1;
      check("s5_abort_hreq", 32'(hreq), 32'd0);
      check("s5_abort_haddr", haddr, 32'd0);
      mem_to_reg = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
`ifdef DCACHE_STATS_EN
      sb_hits = 0; sb_miss = 0;
`endif
      fill_base = 32'h710;
      access(32'h300, 1'b0, 32'h0, 4'h0, st);
      check("s5_reload_stalls", 32'(st), 32'd5);
      check("s5_reload_beats", 32'(lg_addr.size()), 32'd4);
      if (lg_addr.size() > 0) check("s5_reload_addr0", lg_addr[0], 32'h300);
      check("s5_reload_rd", rd, 32'h710);
      idle();
      fill_base = 32'hB0;
      access(32'h100, 1'b0, 32'h0, 4'h0, st);
      check("s5_cleared_stalls", 32'(st), 32'd5);
      check("s5_cleared_rd", rd, 32'hB0);
      idle();
`ifdef DCACHE_STATS_EN
      check("end_hitcount", hit_count, 32'(sb_hits));
      check("end_misscount", miss_count, 32'(sb_miss));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
